// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, branch unit and decode.
// master: the fetch unit. slave: the surroundings (memory, branch unit, decode).
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              branch_valid;
  logic [ADDR_W-1:0] branch_address;
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_radrs;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    input  branch_valid, branch_address, imem_rdata, instr_ready,
    output imem_rd, imem_radrs, instr_out, instr_pc, instr_valid, fifo_level
  );

  modport slave (
    output branch_valid, branch_address, imem_rdata, instr_ready,
    input  imem_rd, imem_radrs, instr_out, instr_pc, instr_valid, fifo_level
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency reads to instruction memory
// and buffers returned {instruction, pc} pairs in a small prefetch FIFO for decode.
// A taken branch flushes the FIFO, drops the read in flight and redirects fetch.
// Optional feature macro: IFU_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W     = 11,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                resetn,
  instr_fetch_unit_if.master  bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         flush_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRD_W = LVL_W + 1;

  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rd_pc;
  logic              inflight;

  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_pc;
  logic              head_valid;

  logic              issue_c;
  logic              push_c;
  logic              pop_c;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [LVL_W-1:0]  after_pop;
  logic [LVL_W-1:0]  level_nxt;
  logic [DATA_W-1:0] head_data_nxt;
  logic [ADDR_W-1:0] head_pc_nxt;
  logic              head_valid_nxt;

  // Issue/push/pop decisions and the next registered head of the FIFO.
  always_comb begin
    issue_c        = 1'b0;
    push_c         = 1'b0;
    pop_c          = 1'b0;
    rd_ptr_nxt     = rd_ptr;
    after_pop      = level_q;
    level_nxt      = level_q;
    head_data_nxt  = '0;
    head_pc_nxt    = '0;
    head_valid_nxt = 1'b0;

    // Credit check uses registered occupancy only, so a same-cycle pop gives no credit.
    issue_c = resetn && !bus.branch_valid &&
              ((CRD_W'(level_q) + CRD_W'(inflight)) < CRD_W'(FIFO_DEPTH));
    push_c  = inflight && !bus.branch_valid;
    pop_c   = head_valid && bus.instr_ready && !bus.branch_valid;

    rd_ptr_nxt = rd_ptr + PTR_W'(pop_c);
    after_pop  = level_q - LVL_W'(pop_c);
    level_nxt  = after_pop + LVL_W'(push_c);

    if (!bus.branch_valid && (level_nxt != '0)) begin
      head_valid_nxt = 1'b1;
      if (after_pop == '0) begin
        head_data_nxt = bus.imem_rdata;
        head_pc_nxt   = rd_pc;
      end else begin
        head_data_nxt = data_q[rd_ptr_nxt];
        head_pc_nxt   = pc_q[rd_ptr_nxt];
      end
    end
  end

  // Fetch PC, in-flight tracking, FIFO pointers/level and registered head outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc   <= RESET_PC;
      rd_pc      <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      head_data  <= '0;
      head_pc    <= '0;
      head_valid <= 1'b0;
    end else begin
      inflight   <= issue_c;
      if (issue_c) begin
        rd_pc <= fetch_pc;
      end
      if (bus.branch_valid) begin
        fetch_pc <= bus.branch_address;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (issue_c) begin
          fetch_pc <= fetch_pc + ADDR_W'(1);
        end
        if (push_c) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        rd_ptr <= rd_ptr_nxt;
      end
      level_q    <= bus.branch_valid ? '0 : level_nxt;
      head_data  <= head_data_nxt;
      head_pc    <= head_pc_nxt;
      head_valid <= head_valid_nxt;
    end
  end

  // FIFO storage; contents are only meaningful below the level count, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      data_q[wr_ptr] <= bus.imem_rdata;
      pc_q[wr_ptr]   <= rd_pc;
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Saturating counters: empty-output cycles and flush cycles since reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!head_valid && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (bus.branch_valid && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

  assign bus.imem_rd     = issue_c;
  assign bus.imem_radrs  = fetch_pc;
  assign bus.instr_out   = head_data;
  assign bus.instr_pc    = head_pc;
  assign bus.instr_valid = head_valid;
  assign bus.fifo_level  = level_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle instruction memory returning {21'h0, addr}.
module tb_instr_fetch_unit;

  logic clk;
  logic resetn;
  int   nerr;
  int   nchk;

  instr_fetch_unit_if bus ();

`ifdef IFU_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  int          exp_stall;
  int          exp_flush;
`endif

  instr_fetch_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: data is the word address, one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_rdata <= 32'(bus.imem_radrs);
  end

`ifdef IFU_PERF_CNT_EN
  // Reference counts of empty-output cycles and branch cycles since reset.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_stall <= 0;
      exp_flush <= 0;
    end else begin
      if (!bus.instr_valid && exp_stall < 65535) exp_stall <= exp_stall + 1;
      if (bus.branch_valid && exp_flush < 65535) exp_flush <= exp_flush + 1;
    end
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle, check reset values, release so the caller is in cycle 0.
  task automatic do_reset(input string tag);
    tick();
    resetn = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 32'(bus.instr_valid), 32'h0);
    chk({tag, "_rst_instr"}, bus.instr_out, 32'h0);
    chk({tag, "_rst_pc"},    32'(bus.instr_pc), 32'h0);
    chk({tag, "_rst_level"}, 32'(bus.fifo_level), 32'h0);
    chk({tag, "_rst_rd"},    32'(bus.imem_rd), 32'h0);
    chk({tag, "_rst_radrs"}, 32'(bus.imem_radrs), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    resetn = 1'b0;
    bus.branch_valid   = 1'b0;
    bus.branch_address = '0;
    bus.instr_ready    = 1'b1;
    bus.imem_rdata     = '0;
    repeat (2) @(posedge clk);

    // 1: streaming from reset, valid from cycle 2, pcs consecutive
    do_reset("t1");
    bus.instr_ready = 1'b1;
    #1;
    chk("t1_c0_rd", 32'(bus.imem_rd), 32'h1);
    chk("t1_c0_radrs", 32'(bus.imem_radrs), 32'h0);
    chk("t1_c0_valid", 32'(bus.instr_valid), 32'h0);
    tick(); #1;
    chk("t1_c1_valid", 32'(bus.instr_valid), 32'h0);
    chk("t1_c1_radrs", 32'(bus.imem_radrs), 32'h1);
    for (int k = 2; k < 10; k++) begin
      tick(); #1;
      chk("t1_valid", 32'(bus.instr_valid), 32'h1);
      chk("t1_pc", 32'(bus.instr_pc), 32'(k - 2));
      chk("t1_instr", bus.instr_out, 32'(k - 2));
      chk("t1_level", 32'(bus.fifo_level), 32'h1);
    end

    // 2: backpressure fills FIFO to 4, fetch stops, release drains in order
    do_reset("t2");
    bus.instr_ready = 1'b0;
    for (int c = 1; c < 10; c++) begin
      tick(); #1;
      if (c == 3) chk("t2_c3_radrs", 32'(bus.imem_radrs), 32'h3);
      if (c == 3) chk("t2_c3_rd", 32'(bus.imem_rd), 32'h1);
      if (c == 4) chk("t2_c4_rd", 32'(bus.imem_rd), 32'h0);
    end
    chk("t2_full_level", 32'(bus.fifo_level), 32'h4);
    chk("t2_full_rd", 32'(bus.imem_rd), 32'h0);
    chk("t2_full_pc", 32'(bus.instr_pc), 32'h0);
    tick();
    bus.instr_ready = 1'b1;
    #1;
    chk("t2_drain_pc0", 32'(bus.instr_pc), 32'h0);
    for (int k = 1; k < 6; k++) begin
      tick(); #1;
      chk("t2_drain_valid", 32'(bus.instr_valid), 32'h1);
      chk("t2_drain_pc", 32'(bus.instr_pc), 32'(k));
      if (k == 1) chk("t2_level_after_pop", 32'(bus.fifo_level), 32'h3);
    end

    // 3: branch to 0x200 during steady stream
    repeat (3) tick();
    tick();
    bus.branch_valid   = 1'b1;
    bus.branch_address = 11'h200;
    #1;
    chk("t3_T_rd", 32'(bus.imem_rd), 32'h0);
    tick();
    bus.branch_valid = 1'b0;
    #1;
    chk("t3_T1_valid", 32'(bus.instr_valid), 32'h0);
    chk("t3_T1_level", 32'(bus.fifo_level), 32'h0);
    chk("t3_T1_rd", 32'(bus.imem_rd), 32'h1);
    chk("t3_T1_radrs", 32'(bus.imem_radrs), 32'h200);
    tick(); #1;
    chk("t3_T2_valid", 32'(bus.instr_valid), 32'h0);
    tick(); #1;
    chk("t3_T3_valid", 32'(bus.instr_valid), 32'h1);
    chk("t3_T3_pc", 32'(bus.instr_pc), 32'h200);
    chk("t3_T3_instr", bus.instr_out, 32'h200);
    tick(); #1;
    chk("t3_T4_pc", 32'(bus.instr_pc), 32'h201);

    // 4: branch near the top of memory, pc wraps to 0
    tick();
    bus.branch_valid   = 1'b1;
    bus.branch_address = 11'h7FE;
    tick();
    bus.branch_valid = 1'b0;
    tick();
    tick(); #1;
    chk("t4_pc_7fe", 32'(bus.instr_pc), 32'h7FE);
    tick(); #1;
    chk("t4_pc_7ff", 32'(bus.instr_pc), 32'h7FF);
    tick(); #1;
    chk("t4_pc_000", 32'(bus.instr_pc), 32'h000);
    chk("t4_instr_000", bus.instr_out, 32'h0);
    tick(); #1;
    chk("t4_pc_001", 32'(bus.instr_pc), 32'h001);

    // back-to-back branches: the last target wins
    tick();
    bus.branch_valid   = 1'b1;
    bus.branch_address = 11'h100;
    tick();
    bus.branch_address = 11'h180;
    tick();
    bus.branch_valid = 1'b0;
    #1;
    chk("b2b_radrs", 32'(bus.imem_radrs), 32'h180);
    tick();
    tick(); #1;
    chk("b2b_valid", 32'(bus.instr_valid), 32'h1);
    chk("b2b_pc", 32'(bus.instr_pc), 32'h180);

    // 5: asynchronous reset with a full FIFO, then restart at RESET_PC
    bus.instr_ready = 1'b0;
    repeat (6) tick();
    #1;
    chk("t5_full_level", 32'(bus.fifo_level), 32'h4);
    do_reset("t5");
    bus.instr_ready = 1'b1;
    #1;
    chk("t5_restart_radrs", 32'(bus.imem_radrs), 32'h0);
    tick();
    tick(); #1;
    chk("t5_restart_valid", 32'(bus.instr_valid), 32'h1);
    chk("t5_restart_pc", 32'(bus.instr_pc), 32'h0);

`ifdef IFU_PERF_CNT_EN
    // 6: counters track branches and empty cycles, then saturate
    do_reset("t6");
    for (int b = 0; b < 3; b++) begin
      repeat (3) tick();
      bus.branch_valid   = 1'b1;
      bus.branch_address = 11'(16 * b);
      tick();
      bus.branch_valid = 1'b0;
    end
    repeat (8) tick();
    #1;
    chk("t6_flush_cnt", 32'(flush_cnt), 32'h3);
    chk("t6_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    bus.branch_valid = 1'b1;
    repeat (70000) tick();
    bus.branch_valid = 1'b0;
    #1;
    chk("t6_stall_sat", 32'(stall_cnt), 32'hFFFF);
    chk("t6_flush_sat", 32'(flush_cnt), 32'hFFFF);
    chk("t6_flush_model", 32'(flush_cnt), 32'(exp_flush));
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
